echo_indication_serializer: RTL and testbench
=============================================

# echo_indication_serializer

Downstream stage of the echo responder. Consumes the `ind_echo` indication method, buffers up to DEPTH indications, and serializes each one into a two-word host message: header, then payload. The output is a RDY/ENA word pipe toward the host indication portal. It decouples the responder's `rule_respond` firing from host backpressure.

## Interface

**Parameters**
- `DEPTH`, default 4: indication buffer depth; power of two, ≥2.
- `METHOD_ID`, default 16'h0000: method identifier placed in header bits [31:16].

**Ports** (reset is synchronous and active-low; single clock)
- `CLK` input 1: clock; all state updates on posedge.
- `nRST` input 1: synchronous active-low reset.
- `ind_echo__RDY` output 1: buffer can accept an indication.
- `ind_echo__ENA` input 1: indication fire.
- `ind_echo_v` input 32: indication payload.
- `msg__RDY` input 1: host pipe can take a word this cycle.
- `msg__ENA` output 1: `msg_v` holds a valid word.
- `msg_v` output 32: message word.
- `msg_last` output 1: current word is the final word of the message (the payload word).

## Operation

**Buffer**
- Circular FIFO of DEPTH × 32 bits.
- Read and write pointers are log2(DEPTH) bits; occupancy is log2(DEPTH)+1 bits.
- `ind_echo__RDY` = (occupancy != DEPTH) && nRST. It is combinational from the registered occupancy.
- Enqueue happens when `ind_echo__ENA && ind_echo__RDY`. `ind_echo__ENA` while RDY is low is ignored: no state change, no error.

**FSM**
- States: IDLE, HDR, PAY. Reset state is IDLE.
- IDLE: `msg__ENA`=0. If occupancy ≠ 0, go to HDR on the next edge.
- HDR: `msg__ENA`=1, `msg_v`=header, `msg_last`=0. On `msg__RDY`, go to PAY.
- PAY: `msg__ENA`=1, `msg_v`=FIFO head, `msg_last`=1. On `msg__RDY`, pop the FIFO.
  - Next state is HDR if post-pop occupancy ≠ 0, counting a same-cycle enqueue.
  - Otherwise next state is IDLE.

**Header word**
- [31:16] = METHOD_ID.
- [15:8] = sequence field (see Configuration).
- [7:0] = 8'd2, the message length in words.

**Ordering and stability**
- Word transfer occurs exactly when `msg__ENA && msg__RDY`.
- While `msg__ENA`=1 and `msg__RDY`=0, `msg_v` and `msg_last` hold constant.
- Payloads leave in acceptance order.

**Simultaneous events**
- Enqueue and pop in the same cycle: occupancy is unchanged and both pointers advance.
- When full, RDY is low, so an enqueue cannot coincide with a full buffer.

**Reset**
- A reset asserted mid-message discards buffered entries and any partially sent message.
- The host must tolerate a truncated message (header without payload).

## Timing

**Reset values** (in the cycle after the nRST-low edge)
- `msg__ENA`=0, `msg_v`=0, `msg_last`=0.
- `ind_echo__RDY`=0 while nRST is low, and 1 in the first cycle after release.
- Occupancy = 0, pointers = 0, FSM = IDLE.

**Latency**
- Indication accepted at edge N: header is presented in cycle N+1 (IDLE→HDR at edge N+1).
- With `msg__RDY` held at 1: header transfers at N+1 and payload transfers at N+2.

**Throughput**
- One message per 2 cycles under continuous `msg__RDY`=1. There is no idle cycle between back-to-back messages.

**Outputs**
- `msg_v` and `msg_last` are registered or decoded from registered state plus FIFO head. Neither depends combinationally on `msg__RDY`.
- `ind_echo__RDY` does not depend on `ind_echo__ENA` or `msg__RDY`.

## Configuration

`ECHO_IND_SEQ_EN`

**Defined**
- An 8-bit sequence counter resets to 0 and increments on each payload transfer, wrapping 255→0.
- Header [15:8] carries the counter value of the message being sent.

**Undefined**
- Header [15:8] = 8'h00.
- The counter is not instantiated.

All other behaviour is identical in both builds.

## Test plan

1. **Reset:** assert nRST=0 for 3 cycles with `ind_echo__ENA`=1.
   - Required: `msg__ENA`=0 and `ind_echo__RDY`=0 during reset; RDY=1 in the first cycle after release.
2. **Single message:** `msg__RDY`=1; enqueue 32'hDEADBEEF at edge N.
   - Required: cycle N+1 carries header 32'h0000_0002 (seq 0), `msg_last`=0.
   - Required: cycle N+2 carries 32'hDEADBEEF, `msg_last`=1.
   - Required: `msg__ENA`=0 at N+3.
3. **Backpressure and full:** `msg__RDY`=0; enqueue 1, 2, 3, 4.
   - Required: `ind_echo__RDY`=0 after the 4th; a 5th ENA with value 5 is ignored.
   - Required: header is held stable for 10 cycles.
   - Release RDY. Required: 8 words stream out, payloads 1, 2, 3, 4, with no gaps.
4. **Simultaneous enq/pop:** occupancy 1, in PAY, `msg__RDY`=1, enqueue 7 in the same cycle.
   - Required: occupancy remains 1 and the next state is HDR.
   - Required: payload 7 follows its header.
5. **Sequence wrap** (`ECHO_IND_SEQ_EN`): send 257 messages.
   - Required: header [15:8] sequence is 0..255, then 0.
   - Without the macro: [15:8] is always 0.
6. **Mid-message reset:** assert nRST in PAY with occupancy 3.
   - Required: IDLE after reset and occupancy 0.
   - Required: no stale payload is emitted afterwards.

Source files
------------

// File: rtl/echo_indication_serializer.sv
// rtl/echo_indication_serializer.sv - buffers ind_echo indications and emits header+payload host messages
// Optional: define ECHO_IND_SEQ_EN to carry an 8-bit message sequence number in header [15:8].
module echo_indication_serializer #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] METHOD_ID = 16'h0000
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        ind_echo__RDY,
  input  logic        ind_echo__ENA,
  input  logic [31:0] ind_echo_v,
  input  logic        msg__RDY,
  output logic        msg__ENA,
  output logic [31:0] msg_v,
  output logic        msg_last
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          enq, pop;
  logic [7:0]    seq_field;

  assign ind_echo__RDY = (count_q != (AW+1)'(DEPTH)) && nRST;
  assign enq = ind_echo__ENA && ind_echo__RDY;
  assign pop = (state_q == S_PAY) && msg__RDY;

`ifdef ECHO_IND_SEQ_EN
  logic [7:0] seq_q;
  always_ff @(posedge CLK) begin
    if (!nRST)    seq_q <= 8'h00;
    else if (pop) seq_q <= seq_q + 8'h01;
  end
  assign seq_field = seq_q;
`else
  assign seq_field = 8'h00;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW+1)'(enq) - (AW+1)'(pop);
  end

  // Leaving PAY looks at post-pop occupancy including a same-cycle enqueue,
  // so back-to-back messages run without an idle cycle.
  always_comb begin
    state_d  = state_q;
    msg__ENA = 1'b0;
    msg_v    = 32'h0;
    msg_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_HDR;
      end
      S_HDR: begin
        msg__ENA = 1'b1;
        msg_v    = {METHOD_ID, seq_field, 8'd2};
        if (msg__RDY) state_d = S_PAY;
      end
      S_PAY: begin
        msg__ENA = 1'b1;
        msg_v    = mem_q[rd_ptr_q];
        msg_last = 1'b1;
        if (msg__RDY) state_d = (count_d != '0) ? S_HDR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) mem_q[wr_ptr_q] <= ind_echo_v;
  end

endmodule

// File: tb/tb_echo_indication_serializer.sv
// tb/tb_echo_indication_serializer.sv - directed self-checking bench for echo_indication_serializer
module tb_echo_indication_serializer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ind_echo__RDY;
  logic        ind_echo__ENA;
  logic [31:0] ind_echo_v;
  logic        msg__RDY;
  logic        msg__ENA;
  logic [31:0] msg_v;
  logic        msg_last;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_seq;

  echo_indication_serializer #(.DEPTH(4), .METHOD_ID(16'h0000)) dut (
    .CLK(CLK), .nRST(nRST),
    .ind_echo__RDY(ind_echo__RDY), .ind_echo__ENA(ind_echo__ENA), .ind_echo_v(ind_echo_v),
    .msg__RDY(msg__RDY), .msg__ENA(msg__ENA), .msg_v(msg_v), .msg_last(msg_last)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] hdr(input logic [7:0] s);
`ifdef ECHO_IND_SEQ_EN
    return {16'h0000, s, 8'd2};
`else
    return {16'h0000, 8'h00 & s, 8'd2};
`endif
  endfunction

  task automatic do_reset();
    nRST = 1'b0;
    step();
    check("rst_ena", 32'(msg__ENA), 32'd0);
    nRST = 1'b1;
    exp_seq = 8'h00;
  endtask

  initial begin
    nRST = 1'b0; ind_echo__ENA = 1'b1; ind_echo_v = 32'h0; msg__RDY = 1'b0; exp_seq = 8'h00;
    // Reset held 3 cycles with ENA asserted
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_msg_ena", 32'(msg__ENA), 32'd0);
      check("rst_rdy", 32'(ind_echo__RDY), 32'd0);
      check("rst_msg_v", msg_v, 32'h0);
      check("rst_last", 32'(msg_last), 32'd0);
    end
    nRST = 1'b1; ind_echo__ENA = 1'b0;
    #1;
    check("rdy_after_rst", 32'(ind_echo__RDY), 32'd1);

    // Single message
    msg__RDY = 1'b1; ind_echo__ENA = 1'b1; ind_echo_v = 32'hDEADBEEF;
    step();
    ind_echo__ENA = 1'b0;
    check("t2_idle", 32'(msg__ENA), 32'd0);
    step();
    check("t2_hdr_ena", 32'(msg__ENA), 32'd1);
    check("t2_hdr", msg_v, 32'h0000_0002);
    check("t2_hdr_last", 32'(msg_last), 32'd0);
    step();
    check("t2_pay", msg_v, 32'hDEADBEEF);
    check("t2_pay_last", 32'(msg_last), 32'd1);
    step();
    check("t2_done", 32'(msg__ENA), 32'd0);
    exp_seq = exp_seq + 8'd1;

    // Backpressure and full
    msg__RDY = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("t3_rdy_pre", 32'(ind_echo__RDY), 32'd1);
      ind_echo__ENA = 1'b1; ind_echo_v = 32'(i);
      step();
    end
    check("t3_full_rdy", 32'(ind_echo__RDY), 32'd0);
    ind_echo_v = 32'd5;
    step();
    ind_echo__ENA = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_hdr", msg_v, hdr(exp_seq));
      check("t3_hold_ena", 32'(msg__ENA), 32'd1);
      step();
    end
    msg__RDY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t3_hdr", msg_v, hdr(exp_seq));
      check("t3_hdr_ena", 32'(msg__ENA), 32'd1);
      step();
      check("t3_pay", msg_v, 32'(i));
      check("t3_pay_ena", 32'(msg__ENA), 32'd1);
      check("t3_pay_last", 32'(msg_last), 32'd1);
      step();
      exp_seq = exp_seq + 8'd1;
    end
    check("t3_drained", 32'(msg__ENA), 32'd0);

    // Simultaneous enqueue and pop
    ind_echo__ENA = 1'b1; ind_echo_v = 32'd9;
    step();
    ind_echo__ENA = 1'b0;
    step();
    check("t4_hdr", msg_v, hdr(exp_seq));
    step();
    check("t4_pay9", msg_v, 32'd9);
    ind_echo__ENA = 1'b1; ind_echo_v = 32'd7;
    step();
    ind_echo__ENA = 1'b0;
    exp_seq = exp_seq + 8'd1;
    check("t4_occ", 32'(dut.count_q), 32'd1);
    check("t4_next_hdr_ena", 32'(msg__ENA), 32'd1);
    check("t4_next_hdr_last", 32'(msg_last), 32'd0);
    check("t4_hdr2", msg_v, hdr(exp_seq));
    step();
    check("t4_pay7", msg_v, 32'd7);
    step();
    check("t4_idle", 32'(msg__ENA), 32'd0);

    // Sequence wrap over 257 messages
    do_reset();
    msg__RDY = 1'b1;
    for (int k = 0; k < 257; k++) begin
      ind_echo__ENA = 1'b1; ind_echo_v = 32'h1000 + 32'(k);
      step();
      ind_echo__ENA = 1'b0;
      step();
      check("t5_hdr", msg_v, hdr(exp_seq));
      step();
      check("t5_pay", msg_v, 32'h1000 + 32'(k));
      step();
      exp_seq = exp_seq + 8'd1;
    end

    // Mid-message reset
    msg__RDY = 1'b0;
    for (int i = 11; i <= 13; i++) begin
      ind_echo__ENA = 1'b1; ind_echo_v = 32'(i);
      step();
    end
    ind_echo__ENA = 1'b0;
    msg__RDY = 1'b1;
    step();
    msg__RDY = 1'b0;
    check("t6_in_pay", 32'(msg_last), 32'd1);
    check("t6_occ3", 32'(dut.count_q), 32'd3);
    do_reset();
    check("t6_occ0", 32'(dut.count_q), 32'd0);
    msg__RDY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t6_quiet", 32'(msg__ENA), 32'd0);
      step();
    end
    ind_echo__ENA = 1'b1; ind_echo_v = 32'd44;
    step();
    ind_echo__ENA = 1'b0;
    step();
    check("t6_hdr", msg_v, hdr(8'h00));
    step();
    check("t6_pay", msg_v, 32'd44);
    step();
    check("t6_idle", 32'(msg__ENA), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
